// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: execute-command codes, status-register
// bit positions, FSM state encoding and command classification.
package alu_arbiter_pkg;

    localparam logic [3:0] EXE_ADD = 4'h0;
    localparam logic [3:0] EXE_ADC = 4'h1;
    localparam logic [3:0] EXE_SUB = 4'h2;
    localparam logic [3:0] EXE_SBC = 4'h3;
    localparam logic [3:0] EXE_CMP = 4'h4;
    localparam logic [3:0] EXE_MOV = 4'h5;
    localparam logic [3:0] EXE_MVN = 4'h6;
    localparam logic [3:0] EXE_AND = 4'h7;
    localparam logic [3:0] EXE_ORR = 4'h8;
    localparam logic [3:0] EXE_EOR = 4'h9;
    localparam logic [3:0] EXE_TST = 4'hA;
    localparam logic [3:0] EXE_LDR = 4'hB;
    localparam logic [3:0] EXE_STR = 4'hC;

    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ARITH = 2'd1,
        CLS_LOGIC = 2'd2
    } op_class_e;

    // Decides which status bits an op with s=1 is allowed to write.
    function automatic op_class_e classify(input logic [3:0] cmd);
        op_class_e cls;
        case (cmd)
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_CMP:          cls = CLS_ARITH;
            EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR, EXE_TST: cls = CLS_LOGIC;
            default:                                              cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Two-way round-robin picker: grants the single valid requester, or the
// favoured one (ptr_i=0 favours r0) when both are valid.
module alu_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (r0) and the auxiliary
// sequencer (r1); owns the {Z,C,N,V} status register and registers all responses.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CMD_W    = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_val1,
    input  logic [WIDTH-1:0] r0_val2,
    input  logic [CMD_W-1:0] r0_cmd,
    input  logic             r0_s,
    input  logic             r0_lock,
    output logic             r0_rsp_valid,
    output logic [WIDTH-1:0] r0_rsp_result,
    output logic [3:0]       r0_rsp_sr,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_val1,
    input  logic [WIDTH-1:0] r1_val2,
    input  logic [CMD_W-1:0] r1_cmd,
    input  logic             r1_s,
    input  logic             r1_lock,
    output logic             r1_rsp_valid,
    output logic [WIDTH-1:0] r1_rsp_result,
    output logic [3:0]       r1_rsp_sr,

    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic             alu_cin,
    output logic [CMD_W-1:0] alu_exe_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_sr,

    output logic [3:0]       status
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]       status_q, status_d;
    logic [1:0]       rsp_valid_q;
    logic [WIDTH-1:0] r0_result_q, r1_result_q;
    logic [3:0]       r0_sr_q, r1_sr_q;

    logic [1:0]       rr_grant;
    logic [1:0]       grant;
    logic             gnt_any;
    logic             gnt_id;
    logic [WIDTH-1:0] gnt_val1, gnt_val2;
    logic [CMD_W-1:0] gnt_cmd;
    logic             gnt_s, gnt_lock;
    logic [CNT_W-1:0] run_len;

    // Only status bits the command class owns are replaced; the rest carry over.
    function automatic logic [3:0] merge_flags(input op_class_e cls,
                                               input logic [3:0] cur,
                                               input logic [3:0] alu_flags);
        logic [3:0] nxt;
        nxt = cur;
        case (cls)
            CLS_ARITH: nxt = alu_flags;
            CLS_LOGIC: begin
                nxt[SR_Z] = alu_flags[SR_Z];
                nxt[SR_N] = alu_flags[SR_N];
            end
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    alu_rr_pick u_rr_pick (
        .valid_i ({r1_valid, r0_valid}),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant)
    );

    always_comb begin
        grant = 2'b00;
        if (rst) begin
            case (state_q)
                ST_IDLE: grant = rr_grant;
                ST_OWN0: grant = {1'b0, r0_valid};
                ST_OWN1: grant = {r1_valid, 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_any = |grant;
    assign gnt_id  = grant[1];

    always_comb begin
        gnt_val1 = '0;
        gnt_val2 = '0;
        gnt_cmd  = '0;
        gnt_s    = 1'b0;
        gnt_lock = 1'b0;
        if (grant[1]) begin
            gnt_val1 = r1_val1;
            gnt_val2 = r1_val2;
            gnt_cmd  = r1_cmd;
            gnt_s    = r1_s;
            gnt_lock = r1_lock;
        end else if (grant[0]) begin
            gnt_val1 = r0_val1;
            gnt_val2 = r0_val2;
            gnt_cmd  = r0_cmd;
            gnt_s    = r0_s;
            gnt_lock = r0_lock;
        end
    end

    // run_len counts the op being granted now, so the LOCK_MAX-th consecutive
    // locked op is the last one before the grant is forcibly released.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        run_len    = (state_q == ST_IDLE) ? CNT_ONE : lock_cnt_q + CNT_ONE;
        if (state_q == ST_IDLE && r0_valid && r1_valid && gnt_any) begin
            ptr_d = ~gnt_id;
        end
        if (gnt_any) begin
            if (gnt_lock && (run_len < CNT_MAX)) begin
                state_d    = gnt_id ? ST_OWN1 : ST_OWN0;
                lock_cnt_d = run_len;
            end else begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
                if (gnt_lock) begin
                    ptr_d = ~gnt_id;
                end
            end
        end
    end

    always_comb begin
        status_d = status_q;
        if (gnt_any && gnt_s) begin
            status_d = merge_flags(classify(4'(gnt_cmd)), status_q, alu_sr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            lock_cnt_q  <= '0;
            status_q    <= 4'b0000;
            rsp_valid_q <= 2'b00;
            r0_result_q <= '0;
            r1_result_q <= '0;
            r0_sr_q     <= 4'b0000;
            r1_sr_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            status_q    <= status_d;
            rsp_valid_q <= grant;
            if (grant[0]) begin
                r0_result_q <= alu_result;
                r0_sr_q     <= alu_sr;
            end
            if (grant[1]) begin
                r1_result_q <= alu_result;
                r1_sr_q     <= alu_sr;
            end
        end
    end

    assign r0_ready      = grant[0];
    assign r1_ready      = grant[1];

    // Carry-in comes from the registered status, so back-to-back ops chain cleanly.
    assign alu_val1      = gnt_val1;
    assign alu_val2      = gnt_val2;
    assign alu_exe_cmd   = gnt_cmd;
    assign alu_cin       = gnt_any & status_q[SR_C];

    assign r0_rsp_valid  = rsp_valid_q[0];
    assign r1_rsp_valid  = rsp_valid_q[1];
    assign r0_rsp_result = r0_result_q;
    assign r1_rsp_result = r1_result_q;
    assign r0_rsp_sr     = r0_sr_q;
    assign r1_rsp_sr     = r1_sr_q;
    assign status        = status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub plus a transaction-level model of
// ownership, fairness, flag merging and one-cycle responses.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W    = 32;
    localparam int LMAX = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   sr;
    } alu_out_t;

    logic         clk, rst;
    logic         r0_valid, r0_ready, r0_s, r0_lock, r0_rsp_valid;
    logic [W-1:0] r0_val1, r0_val2, r0_rsp_result;
    logic [3:0]   r0_cmd, r0_rsp_sr;
    logic         r1_valid, r1_ready, r1_s, r1_lock, r1_rsp_valid;
    logic [W-1:0] r1_val1, r1_val2, r1_rsp_result;
    logic [3:0]   r1_cmd, r1_rsp_sr;
    logic [W-1:0] alu_val1, alu_val2, alu_result;
    logic         alu_cin;
    logic [3:0]   alu_exe_cmd, alu_sr, status;

    logic         sr_ovr_en;
    logic [3:0]   sr_ovr;

    int checks, errors;

    int           m_owner, m_fav, m_run;
    logic [3:0]   m_status;
    logic [1:0]   e_vld;
    logic [W-1:0] e_res [2];
    logic [3:0]   e_sr  [2];

    alu_arbiter #(.WIDTH(W), .CMD_W(4), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_val1(r0_val1), .r0_val2(r0_val2),
        .r0_cmd(r0_cmd), .r0_s(r0_s), .r0_lock(r0_lock), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_result(r0_rsp_result), .r0_rsp_sr(r0_rsp_sr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_val1(r1_val1), .r1_val2(r1_val2),
        .r1_cmd(r1_cmd), .r1_s(r1_s), .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_result(r1_rsp_result), .r1_rsp_sr(r1_rsp_sr),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cin(alu_cin), .alu_exe_cmd(alu_exe_cmd),
        .alu_result(alu_result), .alu_sr(alu_sr), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: plain arithmetic, ARM-style carry (C = no borrow on subtract).
    function automatic alu_out_t alu_calc(logic [3:0] cmd, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        alu_out_t o;
        logic [W:0]   wide;
        logic [W-1:0] bb;
        logic         arith;
        wide = '0; bb = b; arith = 1'b1;
        case (cmd)
            EXE_ADD, EXE_LDR, EXE_STR: wide = {1'b0, a} + {1'b0, b};
            EXE_ADC:          wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            EXE_SUB, EXE_CMP: begin bb = ~b; wide = {1'b0, a} + {1'b0, bb} + 1; end
            EXE_SBC:          begin bb = ~b; wide = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin}; end
            EXE_MOV:          begin wide = {1'b0, b};      arith = 1'b0; end
            EXE_MVN:          begin wide = {1'b0, ~b};     arith = 1'b0; end
            EXE_AND, EXE_TST: begin wide = {1'b0, a & b};  arith = 1'b0; end
            EXE_ORR:          begin wide = {1'b0, a | b};  arith = 1'b0; end
            EXE_EOR:          begin wide = {1'b0, a ^ b};  arith = 1'b0; end
            default:          wide = '0;
        endcase
        o.res   = wide[W-1:0];
        o.sr[3] = (o.res == '0);
        o.sr[1] = o.res[W-1];
        o.sr[2] = arith & wide[W];
        o.sr[0] = arith & (a[W-1] == bb[W-1]) & (o.res[W-1] != a[W-1]);
        return o;
    endfunction

    always_comb begin
        {alu_result, alu_sr} = alu_calc(alu_exe_cmd, alu_val1, alu_val2, alu_cin);
        if (sr_ovr_en) alu_sr = sr_ovr;
    end

    function automatic logic [3:0] model_flags(logic [3:0] cmd, logic s, logic [3:0] f, logic [3:0] cur);
        logic [3:0] n;
        n = cur;
        if (s) begin
            case (cmd)
                EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_CMP: n = f;
                EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR, EXE_TST: n = {f[3], cur[2], f[1], cur[0]};
                default: n = cur;
            endcase
        end
        return n;
    endfunction

    function automatic int model_pick(logic v0, logic v1);
        if (m_owner == 0) return v0 ? 0 : -1;
        if (m_owner == 1) return v1 ? 1 : -1;
        if (v0 && v1) return m_fav;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1; m_fav = 0; m_run = 0; m_status = 4'b0000;
        e_vld = 2'b00;
        e_res[0] = '0; e_res[1] = '0; e_sr[0] = 4'b0; e_sr[1] = 4'b0;
    endtask

    task automatic drive(int n, logic v, logic [3:0] cmd, logic [W-1:0] a, logic [W-1:0] b, logic s, logic lk);
        if (n == 0) begin
            r0_valid = v; r0_cmd = cmd; r0_val1 = a; r0_val2 = b; r0_s = s; r0_lock = lk;
        end else begin
            r1_valid = v; r1_cmd = cmd; r1_val1 = a; r1_val2 = b; r1_s = s; r1_lock = lk;
        end
    endtask

    task automatic idle_inputs();
        drive(0, 1'b0, EXE_ADD, '0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, EXE_ADD, '0, '0, 1'b0, 1'b0);
    endtask

    // Advance one clock and fold the op granted in that cycle into the model.
    task automatic tick();
        int         g, run;
        alu_out_t   o;
        logic       lk, sv, both;
        logic [3:0] cm;
        g = model_pick(r0_valid, r1_valid);
        both = r0_valid && r1_valid;
        lk = 1'b0; sv = 1'b0; cm = '0; o = '0;
        if (g == 0) begin
            o = alu_calc(r0_cmd, r0_val1, r0_val2, m_status[2]); lk = r0_lock; sv = r0_s; cm = r0_cmd;
        end else if (g == 1) begin
            o = alu_calc(r1_cmd, r1_val1, r1_val2, m_status[2]); lk = r1_lock; sv = r1_s; cm = r1_cmd;
        end
        if (sr_ovr_en) o.sr = sr_ovr;
        @(posedge clk);
        #1;
        e_vld = 2'b00;
        if (g >= 0) begin
            e_vld[g] = 1'b1; e_res[g] = o.res; e_sr[g] = o.sr;
            if (m_owner < 0 && both) m_fav = 1 - g;
            run = (m_owner < 0) ? 1 : m_run + 1;
            if (lk && run < LMAX) begin
                m_owner = g; m_run = run;
            end else begin
                if (lk) m_fav = 1 - g;
                m_owner = -1; m_run = 0;
            end
            m_status = model_flags(cm, sv, o.sr, m_status);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; sr_ovr_en = 1'b0; idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; sr_ovr_en = 1'b0; idle_inputs();
        #1 rst = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b required 00", {r0_ready, r1_ready});
        end
        checks++;
        if ({r0_rsp_valid, r1_rsp_valid, status} !== 6'b0) begin
            errors++; $display("FAIL reset_state: rsp_valid=%b status=%b required 00/0000", {r0_rsp_valid, r1_rsp_valid}, status);
        end
        checks++;
        if (r0_rsp_result !== '0 || r1_rsp_result !== '0 || r0_rsp_sr !== 4'b0 || r1_rsp_sr !== 4'b0) begin
            errors++; $display("FAIL reset_rsp_data: got %h/%h sr %b/%b required zeros", r0_rsp_result, r1_rsp_result, r0_rsp_sr, r1_rsp_sr);
        end
        checks++;
        if (alu_val1 !== '0 || alu_val2 !== '0 || alu_cin !== 1'b0) begin
            errors++; $display("FAIL reset_alu_idle: got %h %h %b required zeros", alu_val1, alu_val2, alu_cin);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic e0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, EXE_ADD, $urandom, $urandom, 1'b0, 1'b0);
            drive(1, 1'b1, EXE_SUB, $urandom, $urandom, 1'b0, 1'b0);
            e0 = (i % 2 == 0);
            #1;
            checks++;
            if ({r1_ready, r0_ready} !== {~e0, e0}) begin
                errors++; $display("FAIL rr_grant[%0d]: got r1/r0=%b required %b", i, {r1_ready, r0_ready}, {~e0, e0});
            end
            tick();
            checks++;
            if ({r1_rsp_valid, r0_rsp_valid} !== {~e0, e0}) begin
                errors++; $display("FAIL rr_rsp[%0d]: got r1/r0=%b required %b", i, {r1_rsp_valid, r0_rsp_valid}, {~e0, e0});
            end
            checks++;
            if ((e0 ? r0_rsp_result : r1_rsp_result) !== e_res[e0 ? 0 : 1]) begin
                errors++; $display("FAIL rr_result[%0d]: got %h required %h", i, e0 ? r0_rsp_result : r1_rsp_result, e_res[e0 ? 0 : 1]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 1'b1, EXE_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (r0_rsp_valid !== 1'b1 || r0_rsp_result !== 32'h8000_0000) begin
            errors++; $display("FAIL ovf_result: got v=%b %h required 1 80000000", r0_rsp_valid, r0_rsp_result);
        end
        checks++;
        if (status !== 4'b0011 || r0_rsp_sr !== 4'b0011) begin
            errors++; $display("FAIL ovf_status: got status=%b sr=%b required 0011", status, r0_rsp_sr);
        end
    endtask

    task automatic test_carry_chain();
        do_reset();
        drive(0, 1'b1, EXE_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        tick();
        checks++;
        if (status !== 4'b1100) begin
            errors++; $display("FAIL carry_set: got status=%b required 1100", status);
        end
        drive(0, 1'b1, EXE_ADC, 32'h1, 32'h1, 1'b0, 1'b0);
        #1;
        checks++;
        if (alu_cin !== 1'b1) begin
            errors++; $display("FAIL adc_cin: got %b required 1", alu_cin);
        end
        tick();
        checks++;
        if (r0_rsp_result !== 32'h3) begin
            errors++; $display("FAIL adc_result: got %h required 00000003", r0_rsp_result);
        end
        drive(0, 1'b1, EXE_AND, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (status !== 4'b0110 || r0_rsp_result !== 32'h8000_0000) begin
            errors++; $display("FAIL and_keeps_c: got status=%b res=%h required 0110 80000000", status, r0_rsp_result);
        end
    endtask

    task automatic test_lock_limit();
        do_reset();
        drive(1, 1'b1, EXE_ADD, $urandom, $urandom, 1'b0, 1'b1);
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++; $display("FAIL lock_first: got r1_ready=%b required 1", r1_ready);
        end
        tick();
        for (int k = 2; k <= LMAX; k++) begin
            drive(0, 1'b1, EXE_SUB, $urandom, $urandom, 1'b0, 1'b0);
            drive(1, 1'b1, EXE_ADD, $urandom, $urandom, 1'b0, 1'b1);
            #1;
            checks++;
            if ({r1_ready, r0_ready} !== 2'b10) begin
                errors++; $display("FAIL lock_hold[%0d]: got r1/r0=%b required 10", k, {r1_ready, r0_ready});
            end
            tick();
            checks++;
            if (r1_rsp_valid !== 1'b1 || r1_rsp_result !== e_res[1]) begin
                errors++; $display("FAIL lock_rsp[%0d]: got v=%b %h required 1 %h", k, r1_rsp_valid, r1_rsp_result, e_res[1]);
            end
        end
        drive(1, 1'b1, EXE_ADD, $urandom, $urandom, 1'b0, 1'b1);
        #1;
        checks++;
        if ({r1_ready, r0_ready} !== 2'b01) begin
            errors++; $display("FAIL lock_release: got r1/r0=%b required 01", {r1_ready, r0_ready});
        end
        tick();
        for (int k = 9; k <= 10; k++) begin
            drive(1, 1'b1, EXE_ADD, $urandom, $urandom, 1'b0, 1'b1);
            #1;
            checks++;
            if ({r1_ready, r0_ready} !== 2'b10) begin
                errors++; $display("FAIL lock_regrant[%0d]: got r1/r0=%b required 10", k, {r1_ready, r0_ready});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_no_flags();
        do_reset();
        sr_ovr_en = 1'b1; sr_ovr = 4'b1010;
        drive(0, 1'b1, EXE_ADD, 32'h5, 32'h6, 1'b1, 1'b0);
        tick();
        sr_ovr_en = 1'b0;
        idle_inputs();
        checks++;
        if (status !== 4'b1010) begin
            errors++; $display("FAIL str_setup: got status=%b required 1010", status);
        end
        drive(1, 1'b1, EXE_STR, 32'h0000_1000, 32'h0000_0024, 1'b1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (status !== 4'b1010) begin
            errors++; $display("FAIL str_status: got %b required 1010", status);
        end
        checks++;
        if ({r1_rsp_valid, r0_rsp_valid} !== 2'b10 || r1_rsp_result !== 32'h0000_1024) begin
            errors++; $display("FAIL str_result: got v=%b %h required 10 00001024", {r1_rsp_valid, r0_rsp_valid}, r1_rsp_result);
        end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 12)), rand_word(), rand_word(),
                  1'($urandom), $urandom_range(0, 9) < 3);
            drive(1, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 12)), rand_word(), rand_word(),
                  1'($urandom), $urandom_range(0, 9) < 3);
            #1;
            g = model_pick(r0_valid, r1_valid);
            checks++;
            if ({r1_ready, r0_ready} !== {g == 1, g == 0}) begin
                errors++; $display("FAIL rand_grant[%0d]: got r1/r0=%b required %b", i, {r1_ready, r0_ready}, {g == 1, g == 0});
            end
            tick();
            checks++;
            if ({r1_rsp_valid, r0_rsp_valid} !== e_vld) begin
                errors++; $display("FAIL rand_rsp_valid[%0d]: got %b required %b", i, {r1_rsp_valid, r0_rsp_valid}, e_vld);
            end
            if (e_vld[0]) begin
                checks++;
                if (r0_rsp_result !== e_res[0] || r0_rsp_sr !== e_sr[0]) begin
                    errors++; $display("FAIL rand_r0_rsp[%0d]: got %h/%b required %h/%b", i, r0_rsp_result, r0_rsp_sr, e_res[0], e_sr[0]);
                end
            end
            if (e_vld[1]) begin
                checks++;
                if (r1_rsp_result !== e_res[1] || r1_rsp_sr !== e_sr[1]) begin
                    errors++; $display("FAIL rand_r1_rsp[%0d]: got %h/%b required %h/%b", i, r1_rsp_result, r1_rsp_sr, e_res[1], e_sr[1]);
                end
            end
            checks++;
            if (status !== m_status) begin
                errors++; $display("FAIL rand_status[%0d]: got %b required %b", i, status, m_status);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        drive(0, 1'b1, EXE_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        tick();
        checks++;
        if (r0_rsp_valid !== 1'b1 || status !== 4'b1101) begin
            errors++; $display("FAIL midop_pre: got v=%b status=%b required 1 1101", r0_rsp_valid, status);
        end
        drive(1, 1'b1, EXE_SUB, $urandom, $urandom, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({r1_rsp_valid, r0_rsp_valid, r1_ready, r0_ready} !== 4'b0000 || status !== 4'b0000) begin
            errors++; $display("FAIL midop_reset: got rsp=%b ready=%b status=%b required 00 00 0000",
                               {r1_rsp_valid, r0_rsp_valid}, {r1_ready, r0_ready}, status);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        checks = 0; errors = 0;
        model_reset();
        test_reset();
        test_round_robin();
        test_overflow();
        test_carry_chain();
        test_lock_limit();
        test_store_no_flags();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
